hs_region_engine: RTL and testbench

- Generalised high-score access engine in the jb_core_clk domain.
- Sits between the bridge-side CDC request FIFO and the game RAM high-score port.
- Maps a flat save-image byte offset onto NUM_REGIONS discontiguous RAM regions, with one outstanding access and a configurable RAM read latency.
- Snoops CPU writes to raise a dirty flag, so the save controller knows when the table has changed since the last save.

---
 rtl/hs_region_engine_if.sv | 23 ++
 rtl/hs_region_engine.sv | 155 +++++++++++++++
 tb/tb_hs_region_engine.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/hs_region_engine_if.sv
// Request/response handshake between the bridge-side request FIFO and the
// high-score region engine.
interface hs_region_engine_if #(
  parameter int OFF_W = 7
) ();
  logic             req_valid;
  logic             req_ready;
  logic [OFF_W-1:0] req_offset;
  logic             req_write;
  logic [7:0]       req_wdata;
  logic             rsp_valid;
  logic [7:0]       rsp_data;

  modport master (
    output req_valid, req_offset, req_write, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_offset, req_write, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/hs_region_engine.sv
// High-score access engine: maps a flat save-image offset onto discontiguous
// RAM regions, one access at a time, and snoops CPU writes for a dirty flag.
module hs_region_engine #(
  parameter int                            NUM_REGIONS = 2,
  parameter int                            ADDR_W      = 12,
  parameter int                            OFF_W       = 7,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {12'h57e, 12'h620},
  parameter logic [NUM_REGIONS*OFF_W-1:0]  REGION_LEN  = {7'd3, 7'd80},
  parameter int                            RD_LATENCY  = 1,
  parameter logic [7:0]                    FILL_BYTE   = 8'hFF
) (
  input  logic              jb_core_clk,
  input  logic              reset_n,
  hs_region_engine_if.slave hs,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              dirty_clr_i,
  output logic              dirty_o,
  output logic [OFF_W:0]    total_len_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  function automatic logic [OFF_W:0] regionLen(input int k);
    return {1'b0, REGION_LEN[k*OFF_W +: OFF_W]};
  endfunction

  function automatic logic [OFF_W:0] regionStart(input int k);
    logic [OFF_W:0] s;
    s = '0;
    for (int j = 0; j < NUM_REGIONS; j++) begin
      if (j < k) s = s + regionLen(j);
    end
    return s;
  endfunction

  localparam logic [OFF_W:0] TOTAL_LEN = regionStart(NUM_REGIONS);

  if (NUM_REGIONS < 1 || NUM_REGIONS > 8) begin : gBadRegions
    $error("hs_region_engine: NUM_REGIONS must be 1..8");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : gBadLatency
    $error("hs_region_engine: RD_LATENCY must be 1..4");
  end
  if (int'(TOTAL_LEN) > (1 << OFF_W)) begin : gBadTotal
    $error("hs_region_engine: total region length exceeds the offset space");
  end

  state_e            state_q, state_d;
  logic              accept;
  logic              ready_q;
  logic [ADDR_W-1:0] addr_q;
  logic              mapped_q;
  logic              write_q;
  logic [7:0]        wdata_q;
  logic [1:0]        cnt_q;
  logic [7:0]        rspData_q;
  logic              dirty_q;
  logic              waitLast;
  logic [OFF_W:0]    offExt;
  logic              lookMapped;
  logic [ADDR_W-1:0] lookAddr;
  logic              cpuHit;

  assign offExt   = {1'b0, hs.req_offset};
  assign waitLast = (cnt_q == 2'(RD_LATENCY - 1));

  // Region decode of the incoming offset; only ever captured into addr_q at accept.
  always_comb begin
    lookMapped = 1'b0;
    lookAddr   = '0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      if (offExt >= regionStart(k) && offExt < regionStart(k) + regionLen(k)) begin
        lookMapped = 1'b1;
        lookAddr   = REGION_BASE[k*ADDR_W +: ADDR_W] + ADDR_W'(offExt - regionStart(k));
      end
    end
  end

  always_comb begin
    cpuHit = 1'b0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      if ({1'b0, cpu_addr_i} >= {1'b0, REGION_BASE[k*ADDR_W +: ADDR_W]} &&
          {1'b0, cpu_addr_i} <  {1'b0, REGION_BASE[k*ADDR_W +: ADDR_W]} +
                                (ADDR_W+1)'(REGION_LEN[k*OFF_W +: OFF_W]))
        cpuHit = 1'b1;
    end
  end

  always_ff @(posedge jb_core_clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs.req_valid && ready_q) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = write_q ? IDLE : WAIT;
      WAIT:    if (waitLast) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ready_q lags reset release by one cycle so nothing is accepted on the exit edge.
  always_ff @(posedge jb_core_clk) begin
    if (!reset_n) begin
      ready_q   <= 1'b0;
      addr_q    <= '0;
      mapped_q  <= 1'b0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rspData_q <= '0;
      dirty_q   <= 1'b0;
    end else begin
      ready_q <= (state_d == IDLE);
      if (accept) begin
        addr_q   <= lookMapped ? lookAddr : '0;
        mapped_q <= lookMapped;
        write_q  <= hs.req_write;
        wdata_q  <= hs.req_wdata;
      end
      if (state_q == ISSUE)     cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + 2'd1;
      if (state_q == WAIT && waitLast)
        rspData_q <= mapped_q ? ram_rdata_i : FILL_BYTE;
      if (cpu_wr_i && cpuHit) dirty_q <= 1'b1;
      else if (dirty_clr_i)   dirty_q <= 1'b0;
    end
  end

  assign hs.req_ready  = ready_q;
  assign hs.rsp_valid  = (state_q == RESP);
  assign hs.rsp_data   = rspData_q;
  assign ram_addr_o    = addr_q;
  assign ram_we_o      = (state_q == ISSUE) && write_q && mapped_q;
  assign ram_wdata_o   = ram_we_o ? wdata_q : 8'h00;
  assign dirty_o       = dirty_q;
  assign total_len_o   = TOTAL_LEN;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_hs_region_engine.sv
// Directed bench: default two-region engine (A) and a three-region,
// three-cycle-latency engine (B) sharing clock and reset.
module tb_hs_region_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  int          checks = 0;
  int          errors = 0;

  logic [11:0] ramAddrA, ramAddrB;
  logic        ramWeA, ramWeB;
  logic [7:0]  ramWdataA, ramWdataB;
  logic [7:0]  ramRdataA, ramRdataB;
  logic [7:0]  pipe0B, pipe1B;
  logic        cpuWr;
  logic [11:0] cpuAddr;
  logic        dirtyClr;
  logic        dirtyA, dirtyB;
  logic [7:0]  totalLenA, totalLenB;
  logic        busyA, busyB;

  hs_region_engine_if #(.OFF_W(7)) hsA ();
  hs_region_engine_if #(.OFF_W(7)) hsB ();

  hs_region_engine dutA (
    .jb_core_clk (clk),
    .reset_n     (reset_n),
    .hs          (hsA),
    .ram_addr_o  (ramAddrA),
    .ram_we_o    (ramWeA),
    .ram_wdata_o (ramWdataA),
    .ram_rdata_i (ramRdataA),
    .cpu_wr_i    (cpuWr),
    .cpu_addr_i  (cpuAddr),
    .dirty_clr_i (dirtyClr),
    .dirty_o     (dirtyA),
    .total_len_o (totalLenA),
    .busy_o      (busyA)
  );

  hs_region_engine #(
    .NUM_REGIONS (3),
    .REGION_BASE ({12'h700, 12'h57e, 12'h620}),
    .REGION_LEN  ({7'd4, 7'd3, 7'd80}),
    .RD_LATENCY  (3)
  ) dutB (
    .jb_core_clk (clk),
    .reset_n     (reset_n),
    .hs          (hsB),
    .ram_addr_o  (ramAddrB),
    .ram_we_o    (ramWeB),
    .ram_wdata_o (ramWdataB),
    .ram_rdata_i (ramRdataB),
    .cpu_wr_i    (1'b0),
    .cpu_addr_i  (12'h000),
    .dirty_clr_i (1'b0),
    .dirty_o     (dirtyB),
    .total_len_o (totalLenB),
    .busy_o      (busyB)
  );

  always #5 clk = ~clk;

  // RAM models: byte at address a is a[7:0]^0x43 (0x57f -> 0x3C, 0x701 -> 0x42).
  always @(posedge clk) ramRdataA <= ramAddrA[7:0] ^ 8'h43;

  always @(posedge clk) begin
    pipe0B    <= ramAddrB[7:0] ^ 8'h43;
    pipe1B    <= pipe0B;
    ramRdataB <= pipe1B;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit useB, input logic [6:0] offset, input logic wr, input logic [7:0] wdata);
    if (useB) begin
      hsB.req_valid = 1'b1; hsB.req_offset = offset; hsB.req_write = wr; hsB.req_wdata = wdata;
    end else begin
      hsA.req_valid = 1'b1; hsA.req_offset = offset; hsA.req_write = wr; hsA.req_wdata = wdata;
    end
  endtask

  task automatic dropRequests();
    hsA.req_valid = 1'b0;
    hsB.req_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    hsA.req_valid = 1'b0; hsA.req_offset = '0; hsA.req_write = 1'b0; hsA.req_wdata = '0;
    hsB.req_valid = 1'b0; hsB.req_offset = '0; hsB.req_write = 1'b0; hsB.req_wdata = '0;
    cpuWr = 1'b0; cpuAddr = '0; dirtyClr = 1'b0;

    repeat (3) tick();
    $display("[TB] reset state");
    checkOutput("rst_ready", 32'(hsA.req_ready), 32'd0);
    checkOutput("rst_busy", 32'(busyA), 32'd0);
    checkOutput("rst_rsp_valid", 32'(hsA.rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", 32'(hsA.rsp_data), 32'h00);
    checkOutput("rst_ram_addr", 32'(ramAddrA), 32'h000);
    checkOutput("rst_ram_we", 32'(ramWeA), 32'd0);
    checkOutput("rst_ram_wdata", 32'(ramWdataA), 32'h00);
    checkOutput("rst_dirty", 32'(dirtyA), 32'd0);
    checkOutput("total_len_A", 32'(totalLenA), 32'd83);
    checkOutput("total_len_B", 32'(totalLenB), 32'd87);

    reset_n = 1'b1;
    tick();
    checkOutput("ready_after_rst_A", 32'(hsA.req_ready), 32'd1);
    checkOutput("ready_after_rst_B", 32'(hsB.req_ready), 32'd1);

    $display("[TB] mapped write offset 0x00");
    applyStimulus(1'b0, 7'h00, 1'b1, 8'hA5);
    tick();
    dropRequests();
    checkOutput("wr_we", 32'(ramWeA), 32'd1);
    checkOutput("wr_addr", 32'(ramAddrA), 32'h620);
    checkOutput("wr_wdata", 32'(ramWdataA), 32'hA5);
    checkOutput("wr_ready_low", 32'(hsA.req_ready), 32'd0);
    checkOutput("wr_busy", 32'(busyA), 32'd1);
    tick();
    checkOutput("wr_we_done", 32'(ramWeA), 32'd0);
    checkOutput("wr_ready_back", 32'(hsA.req_ready), 32'd1);
    checkOutput("wr_no_dirty", 32'(dirtyA), 32'd0);

    $display("[TB] read offset 0x51");
    applyStimulus(1'b0, 7'h51, 1'b0, 8'h00);
    tick();
    dropRequests();
    checkOutput("rd51_addr", 32'(ramAddrA), 32'h57f);
    checkOutput("rd51_we", 32'(ramWeA), 32'd0);
    checkOutput("rd51_valid_a1", 32'(hsA.rsp_valid), 32'd0);
    tick();
    checkOutput("rd51_valid_a2", 32'(hsA.rsp_valid), 32'd0);
    checkOutput("rd51_ready_a2", 32'(hsA.req_ready), 32'd0);
    tick();
    checkOutput("rd51_valid_a3", 32'(hsA.rsp_valid), 32'd1);
    checkOutput("rd51_data", 32'(hsA.rsp_data), 32'h3C);
    tick();
    checkOutput("rd51_valid_a4", 32'(hsA.rsp_valid), 32'd0);
    checkOutput("rd51_ready_a4", 32'(hsA.req_ready), 32'd1);

    $display("[TB] unmapped read 0x53 and write 0x60");
    applyStimulus(1'b0, 7'h53, 1'b0, 8'h00);
    tick();
    dropRequests();
    checkOutput("rd53_we", 32'(ramWeA), 32'd0);
    repeat (2) tick();
    checkOutput("rd53_valid", 32'(hsA.rsp_valid), 32'd1);
    checkOutput("rd53_data", 32'(hsA.rsp_data), 32'hFF);
    tick();
    applyStimulus(1'b0, 7'h60, 1'b1, 8'h77);
    tick();
    dropRequests();
    checkOutput("wr60_we", 32'(ramWeA), 32'd0);
    checkOutput("wr60_wdata", 32'(ramWdataA), 32'h00);
    tick();
    checkOutput("wr60_ready_back", 32'(hsA.req_ready), 32'd1);

    $display("[TB] three-region engine, read offset 0x54");
    applyStimulus(1'b1, 7'h54, 1'b0, 8'h00);
    tick();
    dropRequests();
    checkOutput("b54_addr", 32'(ramAddrB), 32'h701);
    repeat (3) tick();
    checkOutput("b54_valid_a4", 32'(hsB.rsp_valid), 32'd0);
    tick();
    checkOutput("b54_valid_a5", 32'(hsB.rsp_valid), 32'd1);
    checkOutput("b54_data", 32'(hsB.rsp_data), 32'h42);
    tick();
    checkOutput("b54_ready_a6", 32'(hsB.req_ready), 32'd1);

    $display("[TB] dirty snooping");
    cpuWr = 1'b1; cpuAddr = 12'h66f;
    tick();
    cpuWr = 1'b0;
    checkOutput("dirty_66f", 32'(dirtyA), 32'd1);
    dirtyClr = 1'b1;
    tick();
    dirtyClr = 1'b0;
    checkOutput("dirty_clr1", 32'(dirtyA), 32'd0);
    cpuWr = 1'b1; cpuAddr = 12'h670;
    tick();
    cpuWr = 1'b0;
    checkOutput("dirty_670", 32'(dirtyA), 32'd0);
    cpuWr = 1'b1; cpuAddr = 12'h57e; dirtyClr = 1'b1;
    tick();
    cpuWr = 1'b0; dirtyClr = 1'b0;
    checkOutput("dirty_set_wins", 32'(dirtyA), 32'd1);
    dirtyClr = 1'b1;
    tick();
    dirtyClr = 1'b0;
    checkOutput("dirty_clr2", 32'(dirtyA), 32'd0);

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 7'h54, 1'b0, 8'h00);
    tick();
    dropRequests();
    tick();
    checkOutput("mid_busy_wait", 32'(busyB), 32'd1);
    reset_n = 1'b0;
    tick();
    checkOutput("mid_rsp_valid", 32'(hsB.rsp_valid), 32'd0);
    checkOutput("mid_busy", 32'(busyB), 32'd0);
    checkOutput("mid_ready", 32'(hsB.req_ready), 32'd0);
    checkOutput("mid_ram_addr", 32'(ramAddrB), 32'h000);
    checkOutput("mid_rsp_data", 32'(hsB.rsp_data), 32'h00);
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("mid_ready_back", 32'(hsB.req_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("mid_no_rsp", 32'(hsB.rsp_valid), 32'd0);
      checkOutput("mid_no_we", 32'(ramWeB), 32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
